// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: opcodes, FSM states and helpers shared by the multiply/divide unit
package mdu_iter_pkg;
  localparam int MDU_OP_W = 4;
  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 4'd0,
    MDU_MULTU = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_MTHI  = 4'd4,
    MDU_MTLO  = 4'd5,
    MDU_MADD  = 4'd6,
    MDU_MADDU = 4'd7,
    MDU_MSUB  = 4'd8,
    MDU_MSUBU = 4'd9,
    MDU_NOP   = 4'd10
  } mdu_op_e;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: E-stage request and HI/LO result bundle of the multiply/divide unit
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic                              start;
  logic [mdu_iter_pkg::MDU_OP_W-1:0] op;
  logic [WIDTH-1:0]                  d1;
  logic [WIDTH-1:0]                  d2;
  logic                              flush;
  logic                              busy;
  logic [WIDTH-1:0]                  hi;
  logic [WIDTH-1:0]                  lo;
  logic                              div_by_zero;
  modport master(output start, op, d1, d2, flush, input busy, hi, lo, div_by_zero);
  modport slave(input start, op, d1, d2, flush, output busy, hi, lo, div_by_zero);
endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: combinational signed/unsigned divider; MIN/-1 falls out of the magnitude path as MIN rem 0
module mdu_div_core #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);
  logic             na, nb;
  logic [WIDTH-1:0] ua, ub, uq, ur;
  assign dz = b == '0;
  assign na = sgn && a[WIDTH-1];
  assign nb = sgn && b[WIDTH-1];
  assign ua = na ? -a : a;
  // divisor forced to 1 on zero so the quotient stays defined; the caller discards it
  assign ub = dz ? WIDTH'(1) : nb ? -b : b;
  assign uq = ua / ub;
  assign ur = ua % ub;
  assign q  = (na ^ nb) ? -uq : uq;
  assign r  = na ? -ur : ur;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit holding HI/LO with accumulate, flush-abort and div-by-zero flag
module mdu_iter import mdu_iter_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int HAS_MACC   = 1
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);
  localparam int W2 = 2 * WIDTH;
  state_e              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [MDU_OP_W-1:0] op;
  logic [WIDTH-1:0]    hi, lo, phi, plo, q, r;
  logic [W2-1:0]       acc, sprod, uprod, res;
  logic                dz, dz_p, is_macc, is_mul, is_div, multi, go, last, busy, dbz;
  assign op      = bus.op;
  assign is_macc = HAS_MACC != 0 && (op == MDU_MADD || op == MDU_MADDU || op == MDU_MSUB || op == MDU_MSUBU);
  assign is_mul  = op == MDU_MULT || op == MDU_MULTU || is_macc;
  assign is_div  = op == MDU_DIV || op == MDU_DIVU;
  assign multi   = is_mul || is_div;
  assign go      = bus.start && !bus.flush && state == IDLE;
  assign last    = state == RUN && cnt == CW'(1);
  assign acc     = {hi, lo};
  assign sprod   = {{WIDTH{bus.d1[WIDTH-1]}}, bus.d1} * {{WIDTH{bus.d2[WIDTH-1]}}, bus.d2};
  assign uprod   = {{WIDTH{1'b0}}, bus.d1} * {{WIDTH{1'b0}}, bus.d2};
  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .a  (bus.d1),
    .b  (bus.d2),
    .sgn(op == MDU_DIV),
    .q  (q),
    .r  (r),
    .dz (dz)
  );
  // the whole result is formed at the start edge; RUN only counts down the latency
  assign res = op == MDU_MULT  ? sprod :
               op == MDU_MULTU ? uprod :
               op == MDU_MADD  ? acc + sprod :
               op == MDU_MADDU ? acc + uprod :
               op == MDU_MSUB  ? acc - sprod :
               op == MDU_MSUBU ? acc - uprod : {r, q};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx = bus.flush ? IDLE : state == IDLE ? (go && multi ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  always_comb begin
    busy = state == RUN;
    dbz  = last && dz_p && !bus.flush;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      phi  <= '0;
      plo  <= '0;
      cnt  <= '0;
      dz_p <= 1'b0;
    end else begin
      if (go && multi) begin
        cnt        <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        {phi, plo} <= res;
        dz_p       <= is_div && dz;
      end else if (state == RUN) cnt <= bus.flush ? '0 : cnt - CW'(1);
      if (go && op == MDU_MTHI) hi <= bus.d1;
      if (go && op == MDU_MTLO) lo <= bus.d1;
      if (last && !bus.flush && !dz_p) begin
        hi <= phi;
        lo <= plo;
      end
    end
  end
  assign bus.busy        = busy;
  assign bus.div_by_zero = dbz;
  assign bus.hi          = hi;
  assign bus.lo          = lo;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter against an arithmetic reference model
module tb_mdu_iter;
  import mdu_iter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mdu_iter_if #(.WIDTH(32)) bus();
  mdu_iter_if #(.WIDTH(16)) bus16();
  mdu_iter #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10), .HAS_MACC(1)) dut (
    .clk(clk), .reset(rst_n), .bus(bus));
  mdu_iter #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(10), .HAS_MACC(1)) dut16 (
    .clk(clk), .reset(rst_n), .bus(bus16));
  int tests = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int m_left;
  bit m_dz;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // reference: result by plain arithmetic, latency as a remaining-cycle count
  task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up, acc;
    int sa, sb;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    acc = {m_hi, m_lo};
    sa = a;
    sb = b;
    m_dz = 1'b0;
    case (o)
      MDU_MULT:  begin m_res = sp;       m_left = 5; end
      MDU_MULTU: begin m_res = up;       m_left = 5; end
      MDU_MADD:  begin m_res = acc + sp; m_left = 5; end
      MDU_MADDU: begin m_res = acc + up; m_left = 5; end
      MDU_MSUB:  begin m_res = acc - sp; m_left = 5; end
      MDU_MSUBU: begin m_res = acc - up; m_left = 5; end
      MDU_DIV: begin
        m_left = 10;
        m_dz = (b == 32'd0);
        if (b == 32'd0) m_res = acc;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) m_res = {32'h0, 32'h80000000};
        else m_res = {32'(sa % sb), 32'(sa / sb)};
      end
      MDU_DIVU: begin
        m_left = 10;
        m_dz = (b == 32'd0);
        if (b == 32'd0) m_res = acc;
        else m_res = {a % b, a / b};
      end
      MDU_MTHI: m_hi = a;
      MDU_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0;
      m_lo = '0;
      m_left = 0;
      m_dz = 1'b0;
    end else if (bus.flush) m_left = 0;
    else if (m_left > 0) begin
      if (m_left == 1 && !m_dz) {m_hi, m_lo} = m_res;
      m_left--;
    end else if (bus.start) model_op(bus.op, bus.d1, bus.d2);
  end

  always @(negedge clk) begin
    check("cycle{busy,dbz,hi,lo}", {6'b0, bus.busy, bus.div_by_zero, bus.hi, bus.lo},
          {6'b0, m_left > 0, m_left == 1 && m_dz && !bus.flush, m_hi, m_lo});
    check("start_while_busy", {71'b0, bus.start && bus.busy}, 72'b0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit f);
    step();
    bus.start = 1'b1;
    bus.op = o;
    bus.d1 = a;
    bus.d2 = b;
    bus.flush = f;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 50) begin
      step();
      n++;
    end
    check("wait_idle_timeout", {71'b0, n >= 50}, 72'b0);
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 15)) - 32'd8;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.d1 = '0; bus.d2 = '0;
    bus16.start = 1'b0; bus16.flush = 1'b0; bus16.op = '0; bus16.d1 = '0; bus16.d2 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_state", {6'b0, bus.busy, bus.div_by_zero, bus.hi, bus.lo}, 72'h0);
    issue(MDU_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      check("mult_busy", {71'b0, bus.busy}, 72'd1);
      step();
    end
    check("mult_done_busy", {71'b0, bus.busy}, 72'd0);
    check("mult_hi_lo", {8'b0, bus.hi, bus.lo}, {8'b0, 64'hFFFFFFFF_FFFFFFEB});
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    repeat (10) step();
    check("div_hi_lo", {8'b0, bus.hi, bus.lo}, {8'b0, 64'hFFFFFFFF_FFFFFFFD});
    issue(MDU_DIVU, 32'd7, 32'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      check("divu0_dbz", {70'b0, bus.busy, bus.div_by_zero}, {70'b0, 1'b1, k == 10});
      step();
    end
    check("divu0_hi_lo", {6'b0, bus.busy, bus.div_by_zero, bus.hi, bus.lo},
          {8'b0, 64'hFFFFFFFF_FFFFFFFD});
    issue(MDU_MTHI, 32'd0, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'd10, 32'd0, 1'b0);
    issue(MDU_MADD, 32'd4, 32'd5, 1'b0);
    wait_idle();
    check("madd_hi_lo", {8'b0, bus.hi, bus.lo}, {8'b0, 64'd30});
    issue(MDU_MSUBU, 32'd1, 32'd31, 1'b0);
    wait_idle();
    check("msubu_hi_lo", {8'b0, bus.hi, bus.lo}, {8'b0, 64'hFFFFFFFF_FFFFFFFF});
    issue(MDU_DIV, 32'd100, 32'd3, 1'b0);
    repeat (3) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_abort", {6'b0, bus.busy, bus.div_by_zero, bus.hi, bus.lo},
          {8'b0, 64'hFFFFFFFF_FFFFFFFF});
    repeat (10) step();
    check("flush_no_late_write", {8'b0, bus.hi, bus.lo}, {8'b0, 64'hFFFFFFFF_FFFFFFFF});
    issue(MDU_MTHI, 32'h1234, 32'd0, 1'b0);
    check("mthi", {39'b0, bus.busy, bus.hi}, {40'b0, 32'h1234});
    issue(MDU_MTHI, 32'h5678, 32'd0, 1'b1);
    check("mthi_flushed", {40'b0, bus.hi}, {40'b0, 32'h1234});
    issue(MDU_MULT, 32'd5, 32'd6, 1'b0);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check("reset_mid_mult", {7'b0, bus.busy, bus.hi, bus.lo}, 72'h0);
    step();
    rst_n = 1'b1;
    step();
    bus16.start = 1'b1; bus16.op = MDU_MULT; bus16.d1 = 16'hFFFD; bus16.d2 = 16'd7;
    step();
    bus16.start = 1'b0;
    check("w16_busy", {71'b0, bus16.busy}, 72'd1);
    step();
    check("w16_mult", {39'b0, bus16.busy, bus16.hi, bus16.lo}, {40'b0, 32'hFFFF_FFEB});
    for (int i = 0; i < 1500; i++) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      bus.flush = ($urandom_range(0, 24) == 0);
      bus.start = (m_left == 0) && ($urandom_range(0, 2) == 0);
      bus.op = 4'($urandom_range(0, 15));
      bus.d1 = rnd();
      bus.d2 = rnd();
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    rst_n = 1'b1;
    wait_idle();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
